sub_381bit_seq: RTL and testbench

Multi-cycle wide subtractor computing DIFF = A − B − borrow_in over WIDTH-bit operands, one CHUNK-bit slice per clock, LSB slice first, with the borrow rippled between slices in a register. It is the inverse-operation companion of the combinational wide-adder datapath. Its purpose is to trade latency for area on operands too wide for a single-cycle lookahead path. Operands enter and results leave through valid/ready handshakes.

---
 rtl/sub_381bit_seq_if.sv | 26 ++
 rtl/sub_381bit_seq.sv | 116 +++++++++++
 tb/tb_sub_381bit_seq.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/sub_381bit_seq_if.sv
// Operand/result handshake bundle for the sequential wide subtractor.
//   master : operand source and result consumer (drives in_valid, operands, out_ready)
//   slave  : the subtractor (drives in_ready, out_valid, diff, borrow_out)
interface sub_381bit_seq_if #(
    parameter int unsigned WIDTH = 381
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] minuend;
    logic [WIDTH-1:0] subtrahend;
    logic             borrow_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    modport master (
        output in_valid, minuend, subtrahend, borrow_in, out_ready,
        input  in_ready, out_valid, diff, borrow_out
    );

    modport slave (
        input  in_valid, minuend, subtrahend, borrow_in, out_ready,
        output in_ready, out_valid, diff, borrow_out
    );
endinterface

// File: rtl/sub_381bit_seq.sv
// Multi-cycle wide subtractor: diff = (minuend - subtrahend - borrow_in) mod 2^WIDTH,
// one CHUNK-bit slice per clock, LSB slice first, borrow rippled in a register.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of sub_381bit_seq_if (operand in / result out handshakes)
module sub_381bit_seq #(
    parameter int unsigned WIDTH = 381,
    parameter int unsigned CHUNK = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sub_381bit_seq_if.slave      bus
);
    localparam int unsigned NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int unsigned PADW   = NCHUNK * CHUNK;
    localparam int unsigned PW     = $clog2(PADW);
    localparam int unsigned CNTW   = $clog2(NCHUNK + 1);
    // Position of result bit WIDTH inside the top slice's {carry, sum} word.
    localparam int unsigned TOPB   = WIDTH - (NCHUNK - 1) * CHUNK;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  diff_q;
    logic [CNTW-1:0]   cnt_q;
    logic              borrow_q;
    logic              borrow_out_q;
    logic              in_ready_q;
    logic              out_valid_q;

    logic [PADW-1:0]   a_pad;
    logic [PADW-1:0]   b_pad;
    logic [PW-1:0]     off;
    logic [CHUNK-1:0]  a_sl;
    logic [CHUNK-1:0]  nb_sl;
    logic              nborrow;
    logic [CHUNK:0]    sum;
    logic              borrow_fin;
    logic [WIDTH-1:0]  diff_nxt;

    // Current slice: A + ~B + ~borrow; pad bits above WIDTH are dropped on write-back.
    always_comb begin
        a_pad    = PADW'(a_q);
        b_pad    = PADW'(b_q);
        off      = PW'(cnt_q) * PW'(CHUNK);
        a_sl     = a_pad[off +: CHUNK];
        nb_sl    = ~b_pad[off +: CHUNK];
        nborrow  = ~borrow_q;
        sum      = (CHUNK+1)'(a_sl) + (CHUNK+1)'(nb_sl) + (CHUNK+1)'(nborrow);
        // With zero-extended operands, bit WIDTH of the padded result is the true borrow.
        borrow_fin = (TOPB == CHUNK) ? ~sum[CHUNK] : sum[TOPB];
        diff_nxt = diff_q;
        for (int i = 0; i < int'(CHUNK); i++) begin
            if (int'(off) + i < int'(WIDTH)) begin
                diff_nxt[PW'(int'(off) + i)] = sum[i];
            end
        end
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            diff_q       <= '0;
            cnt_q        <= '0;
            borrow_q     <= 1'b0;
            borrow_out_q <= 1'b0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        a_q        <= bus.minuend;
                        b_q        <= bus.subtrahend;
                        borrow_q   <= bus.borrow_in;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    diff_q   <= diff_nxt;
                    borrow_q <= ~sum[CHUNK];
                    cnt_q    <= cnt_q + CNTW'(1);
                    if (cnt_q == CNTW'(NCHUNK - 1)) begin
                        borrow_out_q <= borrow_fin;
                        out_valid_q  <= 1'b1;
                        state_q      <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_out_q;
endmodule

// File: tb/tb_sub_381bit_seq.sv
// Self-checking bench for sub_381bit_seq: vector table plus backpressure and reset sequences.
module tb_sub_381bit_seq;
    localparam int unsigned W = 381;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bi;
        logic [W-1:0] d;
        logic         bo;
    } vec_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    sub_381bit_seq_if #(.WIDTH(W)) bus ();

    sub_381bit_seq #(.WIDTH(W), .CHUNK(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One full operation; lat counts edges from the accept edge (inclusive) to out_valid.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                          output logic [W-1:0] d, output logic bo, output int lat);
        int guard;
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!bus.in_ready) chk("in_ready_wait", W'(bus.in_ready), W'(1));
        bus.minuend    = a;
        bus.subtrahend = b;
        bus.borrow_in  = bi;
        bus.in_valid   = 1'b1;
        @(posedge clk); #1;
        bus.in_valid   = 1'b0;
        bus.minuend    = '1;
        bus.subtrahend = '0;
        bus.borrow_in  = 1'b1;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        d  = bus.diff;
        bo = bus.borrow_out;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    vec_t         vecs[9];
    logic [W-1:0] d;
    logic         bo;
    int           lat;
    logic [W-1:0] ones;
    logic [W-1:0] one;

    initial begin
        tests = 0;
        fails = 0;
        ones  = '1;
        one   = W'(1);
        vecs[0] = '{a: W'(5),      b: W'(3), bi: 1'b0, d: W'(2),               bo: 1'b0};
        vecs[1] = '{a: '0,         b: one,   bi: 1'b0, d: ones,                bo: 1'b1};
        vecs[2] = '{a: one << 32,  b: one,   bi: 1'b0, d: W'(64'hFFFF_FFFF),   bo: 1'b0};
        vecs[3] = '{a: one << 352, b: one,   bi: 1'b0, d: {29'd0, {352{1'b1}}}, bo: 1'b0};
        vecs[4] = '{a: ones,       b: ones,  bi: 1'b1, d: ones,                bo: 1'b1};
        vecs[5] = '{a: ones,       b: ones,  bi: 1'b0, d: '0,                  bo: 1'b0};
        vecs[6] = '{a: W'(10),     b: W'(4), bi: 1'b1, d: W'(5),               bo: 1'b0};
        vecs[7] = '{a: '0,         b: '0,    bi: 1'b1, d: ones,                bo: 1'b1};
        vecs[8] = '{a: one << 380, b: one,   bi: 1'b0, d: {1'b0, {380{1'b1}}}, bo: 1'b0};

        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b0;
        bus.minuend    = '0;
        bus.subtrahend = '0;
        bus.borrow_in  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",   W'(bus.in_ready),   W'(1));
        chk("rst_out_valid",  W'(bus.out_valid),  W'(0));
        chk("rst_diff",       bus.diff,           '0);
        chk("rst_borrow_out", W'(bus.borrow_out), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].bi, d, bo, lat);
            chk($sformatf("v%0d_diff", i),       d,             vecs[i].d);
            chk($sformatf("v%0d_borrow", i),     W'(bo),        W'(vecs[i].bo));
            chk($sformatf("v%0d_latency", i),    W'(lat),       W'(13));
            chk($sformatf("v%0d_in_ready", i),   W'(bus.in_ready),  W'(1));
            chk($sformatf("v%0d_out_valid", i),  W'(bus.out_valid), W'(0));
        end

        // Backpressure: result held for 5 cycles, stray in_valid ignored.
        bus.minuend = W'(100); bus.subtrahend = W'(1); bus.borrow_in = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp_latency", W'(lat), W'(13));
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                bus.minuend  = W'(7);
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(posedge clk); #1;
            chk($sformatf("bp%0d_out_valid", k), W'(bus.out_valid),  W'(1));
            chk($sformatf("bp%0d_diff", k),      bus.diff,           W'(99));
            chk($sformatf("bp%0d_borrow", k),    W'(bus.borrow_out), W'(0));
            chk($sformatf("bp%0d_in_ready", k),  W'(bus.in_ready),   W'(0));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("bp_release_out_valid", W'(bus.out_valid), W'(0));
        chk("bp_release_in_ready",  W'(bus.in_ready),  W'(1));
        repeat (3) @(posedge clk);
        #1;
        chk("bp_no_capture_valid", W'(bus.out_valid), W'(0));
        chk("bp_no_capture_ready", W'(bus.in_ready),  W'(1));

        // Asynchronous reset mid-operation, during slice 6.
        bus.minuend = ones; bus.subtrahend = W'(12345); bus.borrow_in = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready",   W'(bus.in_ready),   W'(1));
        chk("arst_out_valid",  W'(bus.out_valid),  W'(0));
        chk("arst_diff",       bus.diff,           '0);
        chk("arst_borrow_out", W'(bus.borrow_out), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready",  W'(bus.in_ready),  W'(1));
        chk("post_rst_out_valid", W'(bus.out_valid), W'(0));
        run_op(W'(10), W'(4), 1'b0, d, bo, lat);
        chk("post_rst_diff",    d,      W'(6));
        chk("post_rst_borrow",  W'(bo), W'(0));
        chk("post_rst_latency", W'(lat), W'(13));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
